// File: rtl/game_flow_fsm.sv
// rtl/game_flow_fsm.sv - game flow state machine: start screen, intro, rounds, pause, game over
module game_flow_fsm #(
    parameter int NUM_ROUNDS       = 3,
    parameter int INTRO_CYCLES     = 65_000_000,
    parameter int ROUND_END_CYCLES = 32_500_000,
    parameter int LOCKOUT_CYCLES   = 32_500_000,
    parameter int BTN_XPOS         = 400,
    parameter int BTN_YPOS         = 300,
    parameter int BTN_W            = 224,
    parameter int BTN_H            = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            left_mouse,
    input  logic                            right_mouse,
    input  logic [11:0]                     mouse_xpos,
    input  logic [11:0]                     mouse_ypos,
    input  logic                            round_done,
    input  logic                            game_lost,
    output logic                            start_screen_enable,
    output logic                            intro_enable,
    output logic                            game_enable,
    output logic                            paused,
    output logic                            game_end_enable,
    output logic                            round_start,
    output logic [$clog2(NUM_ROUNDS+1)-1:0] round_idx,
    output logic                            game_won
);

    localparam int RW    = $clog2(NUM_ROUNDS + 1);
    localparam int MAX_A = (INTRO_CYCLES > ROUND_END_CYCLES) ? INTRO_CYCLES : ROUND_END_CYCLES;
    localparam int MAXC  = (MAX_A > LOCKOUT_CYCLES) ? MAX_A : LOCKOUT_CYCLES;
    localparam int CW    = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    // Counters are loaded with length-1 so each timed state lasts exactly its length.
    localparam logic [CW-1:0] INTRO_LOAD = CW'(INTRO_CYCLES - 1);
    localparam logic [CW-1:0] RE_LOAD    = CW'(ROUND_END_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LOAD  = CW'(LOCKOUT_CYCLES - 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

    // Button bounds in 13 bits so edge + size never wraps.
    localparam logic [12:0] X_LO = 13'(BTN_XPOS);
    localparam logic [12:0] X_HI = 13'(BTN_XPOS + BTN_W);
    localparam logic [12:0] Y_LO = 13'(BTN_YPOS);
    localparam logic [12:0] Y_HI = 13'(BTN_YPOS + BTN_H);

    typedef enum logic [2:0] {
        START     = 3'd0,
        INTRO     = 3'd1,
        RUNNING   = 3'd2,
        PAUSED    = 3'd3,
        ROUND_END = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    // Enable vector order: {start, intro, game, paused, game_end}.
    // ROUND_END keeps the game scene up, so it shares game_enable.
    function automatic logic [4:0] enables_for(input state_t s);
        case (s)
            INTRO:     return 5'b01000;
            RUNNING:   return 5'b00100;
            PAUSED:    return 5'b00010;
            ROUND_END: return 5'b00100;
            GAME_OVER: return 5'b00001;
            default:   return 5'b10000;
        endcase
    endfunction

    state_t        state;
    logic [4:0]    en_q;
    logic [CW-1:0] cnt;
    logic          armed;
    logic          left_prev;
    logic          right_prev;

    logic          lclick;
    logic          rclick;
    logic          hit;
    logic [12:0]   x13;
    logic [12:0]   y13;

    assign lclick = left_mouse & ~left_prev;
    assign rclick = right_mouse & ~right_prev;
    assign x13    = {1'b0, mouse_xpos};
    assign y13    = {1'b0, mouse_ypos};
    assign hit    = (x13 >= X_LO) && (x13 < X_HI) && (y13 >= Y_LO) && (y13 < Y_HI);

    assign {start_screen_enable, intro_enable, game_enable, paused, game_end_enable} = en_q;

    // Single registered FSM: state, outputs, shared counter and click edge history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= START;
            en_q        <= 5'b10000;
            round_start <= 1'b0;
            round_idx   <= '0;
            game_won    <= 1'b0;
            cnt         <= '0;
            armed       <= 1'b0;
            left_prev   <= 1'b1;
            right_prev  <= 1'b1;
        end else begin
            left_prev   <= left_mouse;
            right_prev  <= right_mouse;
            round_start <= 1'b0;
            case (state)
                START: begin
                    if (lclick && hit) begin
                        state     <= INTRO;
                        en_q      <= enables_for(INTRO);
                        round_idx <= '0;
                        game_won  <= 1'b0;
                        cnt       <= INTRO_LOAD;
                    end
                end
                INTRO: begin
                    if (cnt == '0) begin
                        state       <= RUNNING;
                        en_q        <= enables_for(RUNNING);
                        round_start <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RUNNING: begin
                    if (game_lost || (round_done && round_idx == LAST_ROUND)) begin
                        state    <= GAME_OVER;
                        en_q     <= enables_for(GAME_OVER);
                        game_won <= ~game_lost;
                        cnt      <= LOCK_LOAD;
                        armed    <= 1'b0;
                    end else if (round_done) begin
                        state <= ROUND_END;
                        en_q  <= enables_for(ROUND_END);
                        cnt   <= RE_LOAD;
                    end else if (rclick) begin
                        state <= PAUSED;
                        en_q  <= enables_for(PAUSED);
                    end
                end
                PAUSED: begin
                    if (rclick) begin
                        state <= RUNNING;
                        en_q  <= enables_for(RUNNING);
                    end
                end
                ROUND_END: begin
                    if (cnt == '0) begin
                        state     <= INTRO;
                        en_q      <= enables_for(INTRO);
                        round_idx <= round_idx + RW'(1);
                        cnt       <= INTRO_LOAD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                GAME_OVER: begin
                    // armed goes high at the end of the last lockout cycle.
                    if (armed && lclick) begin
                        state <= START;
                        en_q  <= enables_for(START);
                    end else if (cnt == '0) begin
                        armed <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state     <= START;
                    en_q      <= enables_for(START);
                    round_idx <= '0;
                    game_won  <= 1'b0;
                    cnt       <= '0;
                    armed     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/game_flow_fsm.md
GAME_FLOW_FSM -- requirements
Module: game_flow_fsm

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_ROUNDS, 3, rounds per game (>=1)
- INTRO_CYCLES, 65_000_000, length of the pre-round intro, in clk cycles (>=1)
- ROUND_END_CYCLES, 32_500_000, pause between rounds, in clk cycles (>=1)
- LOCKOUT_CYCLES, 32_500_000, click-ignore window on entering GAME_OVER (>=1)
- BTN_XPOS, 400, start button left edge, in pixels
- BTN_YPOS, 300, start button top edge, in pixels
- BTN_W, 224, start button width, in pixels
- BTN_H, 32, start button height, in pixels
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock; all logic on its rising edge
- rst_n, in, 1, synchronous reset, active-low
- left_mouse, in, 1, left button level
- right_mouse, in, 1, right button level
- mouse_xpos, in, 12, cursor x
- mouse_ypos, in, 12, cursor y
- round_done, in, 1, current round completed
- game_lost, in, 1, player failed
- start_screen_enable, out, 1, START state active
- intro_enable, out, 1, INTRO state active
- game_enable, out, 1, RUNNING state active
- paused, out, 1, PAUSED state active
- game_end_enable, out, 1, GAME_OVER state active
- round_start, out, 1, one-cycle pulse at the start of each round
- round_idx, out, $clog2(NUM_ROUNDS+1), current round (0-based)
- game_won, out, 1, all rounds completed; valid in GAME_OVER

Function
REQ-003 States SHALL be START, INTRO, RUNNING, PAUSED, ROUND_END, GAME_OVER.
REQ-004 Exactly one of the five enable outputs SHALL be high per cycle; all outputs SHALL be registered and SHALL change on the same edge as the state.
REQ-005 Click events SHALL be rising edges: lclick = left_mouse & ~left_prev; rclick = right_mouse & ~right_prev. A held button SHALL never produce a second event.
REQ-006 The button hit test SHALL be BTN_XPOS <= x < BTN_XPOS+BTN_W and BTN_YPOS <= y < BTN_YPOS+BTN_H, evaluated with 13-bit sums so no wrap occurs.
REQ-007 START transitions:
- lclick inside the button: go to INTRO, round_idx <= 0, game_won <= 0.
- lclick outside the button: no effect.
REQ-008 INTRO SHALL last exactly INTRO_CYCLES cycles, then go to RUNNING with round_start high for the first RUNNING cycle only.
REQ-009 RUNNING transitions, in priority order:
- game_lost: go to GAME_OVER with game_won = 0.
- round_done with round_idx == NUM_ROUNDS-1: go to GAME_OVER with game_won = 1.
- round_done otherwise: go to ROUND_END.
- rclick: go to PAUSED.
REQ-010 PAUSED transitions:
- rclick: return to RUNNING; round_start SHALL NOT pulse.
- round_done, game_lost and lclick SHALL be ignored.
REQ-011 ROUND_END SHALL last exactly ROUND_END_CYCLES cycles, then go to INTRO with round_idx incremented by 1.
REQ-012 GAME_OVER transitions:
- For the first LOCKOUT_CYCLES cycles, lclick SHALL be ignored.
- After that, lclick (any position) SHALL go to START.
- game_won SHALL hold its value until START is left.
REQ-013 A single shared down-counter of width $clog2(max of the three cycle parameters) SHALL be loaded on entry to INTRO, ROUND_END and GAME_OVER. It SHALL NOT be decremented below 0.
REQ-014 An illegal state encoding SHALL return to START on the next cycle with START's output values.

Reset
REQ-015 While rst_n == 0 at a clock edge, the block SHALL load START with these values:
- start_screen_enable = 1
- all other enables = 0
- round_start = 0, round_idx = 0, game_won = 0
- counter = 0
REQ-016 During reset, left_prev and right_prev SHALL be set to 1, so a button already held at reset release gives no click.
REQ-017 Reset asserted in any state, including mid-count, SHALL override every other input.

Verification (bench parameters: NUM_ROUNDS=2, INTRO_CYCLES=4, ROUND_END_CYCLES=3, LOCKOUT_CYCLES=5, button at 400,300, size 224x32)
REQ-018 The bench SHALL cover these directed scenarios:
- Click inside at (400,300): INTRO for 4 cycles, then game_enable=1 and round_start high for 1 cycle. Clicks at (624,300) and (399,331): stay in START.
- round_done in RUNNING with round_idx=0: ROUND_END for 3 cycles, INTRO with round_idx=1; a second round_done gives GAME_OVER with game_won=1.
- round_done and game_lost in the same cycle: GAME_OVER with game_won=0.
- rclick in RUNNING gives paused=1; round_done while paused is ignored; a second rclick gives RUNNING with no round_start pulse.
- GAME_OVER: an lclick in lockout cycle 3 is ignored; an lclick in cycle 6 gives START. left_mouse held high from reset release: no transition.
- rst_n low for 1 cycle mid-INTRO: START, round_idx=0, counter=0.
